// File: rtl/stage_mem_pkg.sv
// Shared definitions for the memory-access stage.
//  - Operator encodings for the eight load/store operators (all other
//    operator values are non-memory operations).
//  - Stage FSM state type.
//  - Small decode helpers used by both the stage and the alignment unit.
package stage_mem_pkg;

  localparam logic [7:0] OP_LB  = 8'h20;
  localparam logic [7:0] OP_LH  = 8'h21;
  localparam logic [7:0] OP_LW  = 8'h23;
  localparam logic [7:0] OP_LBU = 8'h24;
  localparam logic [7:0] OP_LHU = 8'h25;
  localparam logic [7:0] OP_SB  = 8'h28;
  localparam logic [7:0] OP_SH  = 8'h29;
  localparam logic [7:0] OP_SW  = 8'h2B;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic logic is_load(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_mem_op(input logic [7:0] op);
    return is_load(op) || is_store(op);
  endfunction

  // Halfword ops need an even address, word ops a multiple of four.
  // Byte ops and non-memory ops are always considered aligned.
  function automatic logic is_aligned(input logic [7:0] op, input logic [1:0] lo);
    logic ok;
    ok = 1'b1;
    case (op)
      OP_LH, OP_LHU, OP_SH: ok = ~lo[0];
      OP_LW, OP_SW:         ok = (lo == 2'b00);
      default:              ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/stage_mem_align.sv
// memory_align: combinational lane steering for the memory stage.
//  operator         in  8   latched operator
//  addr_lo          in  2   effective address bits [1:0]
//  store_data       in  32  rt value for stores
//  read_data        in  32  raw bus read word
//  byte_select      out 4   active byte lanes (bit i = byte offset i)
//  store_replicated out 32  store data replicated across lanes
//  load_extended    out 32  selected lane, sign/zero extended
//  misaligned       out 1   memory op whose address violates its size
module memory_align
  import stage_mem_pkg::*;
(
  input  logic [7:0]  operator,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] read_data,
  output logic [3:0]  byte_select,
  output logic [31:0] store_replicated,
  output logic [31:0] load_extended,
  output logic        misaligned
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    case (addr_lo)
      2'd0:    rd_byte = read_data[7:0];
      2'd1:    rd_byte = read_data[15:8];
      2'd2:    rd_byte = read_data[23:16];
      default: rd_byte = read_data[31:24];
    endcase
    rd_half = addr_lo[1] ? read_data[31:16] : read_data[15:0];

    byte_select      = '0;
    store_replicated = '0;
    load_extended    = '0;
    case (operator)
      OP_LB: begin
        byte_select   = 4'b0001 << addr_lo;
        load_extended = {{24{rd_byte[7]}}, rd_byte};
      end
      OP_LBU: begin
        byte_select   = 4'b0001 << addr_lo;
        load_extended = {24'h0, rd_byte};
      end
      OP_LH: begin
        byte_select   = 4'b0011 << addr_lo;
        load_extended = {{16{rd_half[15]}}, rd_half};
      end
      OP_LHU: begin
        byte_select   = 4'b0011 << addr_lo;
        load_extended = {16'h0, rd_half};
      end
      OP_LW: begin
        byte_select   = 4'b1111;
        load_extended = read_data;
      end
      OP_SB: begin
        byte_select      = 4'b0001 << addr_lo;
        store_replicated = {4{store_data[7:0]}};
      end
      OP_SH: begin
        byte_select      = 4'b0011 << addr_lo;
        store_replicated = {2{store_data[15:0]}};
      end
      OP_SW: begin
        byte_select      = 4'b1111;
        store_replicated = store_data;
      end
      default: ;
    endcase

    misaligned = is_mem_op(operator) && !is_aligned(operator, addr_lo);
  end

endmodule

// File: rtl/stage_mem.sv
// stage_mem: memory-access pipeline stage (owns the EX/MEM latch).
//  clock/reset                     rising-edge clock, async active-high reset
//  operator, register_write_*_,    EX/MEM inputs, captured whenever not stalled
//  store_data
//  stall_request                   holds EX/ID/IF while a bus access is pending
//  register_write_enable/address/  write-back triple to MEM/WB
//  data
//  bus_*                           single-outstanding req/ack data bus
//  memory_error                    1-cycle pulse on misalignment or timeout
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
(
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  operator,
  input  logic        register_write_enable_,
  input  logic [4:0]  register_write_address_,
  input  logic [31:0] register_write_data_,
  input  logic [31:0] store_data,
  output logic        stall_request,
  output logic        register_write_enable,
  output logic [4:0]  register_write_address,
  output logic [31:0] register_write_data,
  output logic        bus_request,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_byte_select,
  output logic [31:0] bus_data_write,
  input  logic [31:0] bus_data_read,
  input  logic        bus_ack,
  output logic        memory_error
);

  localparam logic [31:0] TIMEOUT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic        we_q, we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cnt_q, cnt_d;
  logic        abort_q, abort_d;

  logic [3:0]  al_byte_select;
  logic [31:0] al_store_data;
  logic [31:0] al_load_data;
  logic        al_misaligned;
  logic        in_access;
  logic        timeout_hit;

  memory_align u_align (
    .operator         (op_q),
    .addr_lo          (data_q[1:0]),
    .store_data       (sdata_q),
    .read_data        (bus_data_read),
    .byte_select      (al_byte_select),
    .store_replicated (al_store_data),
    .load_extended    (al_load_data),
    .misaligned       (al_misaligned)
  );

  assign in_access   = (state_q == ST_ACCESS);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_LAST);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    we_d    = we_q;
    waddr_d = waddr_q;
    data_d  = data_q;
    sdata_d = sdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    case (state_q)
      ST_ACCESS: begin
        cnt_d = cnt_q + 32'd1;
        if (bus_ack) begin
          rdata_d = al_load_data;
          abort_d = 1'b0;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          abort_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: begin
        // IDLE and DONE both release the stall, so the latch takes the next op.
        op_d    = operator;
        we_d    = register_write_enable_;
        waddr_d = register_write_address_;
        data_d  = register_write_data_;
        sdata_d = store_data;
        cnt_d   = '0;
        abort_d = 1'b0;
        state_d = (is_mem_op(operator) &&
                   is_aligned(operator, register_write_data_[1:0])) ? ST_ACCESS : ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      data_q  <= '0;
      sdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
      sdata_q <= sdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  // All outputs derive from cleared state, so reset zeroes them immediately.
  always_comb begin
    stall_request   = in_access;
    bus_request     = in_access;
    bus_write       = in_access && is_store(op_q);
    bus_address     = in_access ? {data_q[31:2], 2'b00} : '0;
    bus_byte_select = in_access ? al_byte_select : '0;
    bus_data_write  = in_access ? al_store_data : '0;

    register_write_address = waddr_q;
    register_write_data    = data_q;
    register_write_enable  = 1'b0;
    memory_error           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        register_write_enable = we_q && !is_mem_op(op_q);
        memory_error          = al_misaligned;
      end
      ST_DONE: begin
        register_write_enable = we_q && is_load(op_q) && !abort_q;
        memory_error          = abort_q;
        if (is_load(op_q)) begin
          register_write_data = rdata_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stage_mem.sv
module tb_stage_mem;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  operator;
  logic        register_write_enable_;
  logic [4:0]  register_write_address_;
  logic [31:0] register_write_data_;
  logic [31:0] store_data;
  logic        stall_request;
  logic        register_write_enable;
  logic [4:0]  register_write_address;
  logic [31:0] register_write_data;
  logic        bus_request;
  logic        bus_write;
  logic [31:0] bus_address;
  logic [3:0]  bus_byte_select;
  logic [31:0] bus_data_write;
  logic [31:0] bus_data_read;
  logic        bus_ack;
  logic        memory_error;

  localparam int TIMEOUT = 4;

  always #5 clock = ~clock;

  stage_mem #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .operator                (operator),
    .register_write_enable_  (register_write_enable_),
    .register_write_address_ (register_write_address_),
    .register_write_data_    (register_write_data_),
    .store_data              (store_data),
    .stall_request           (stall_request),
    .register_write_enable   (register_write_enable),
    .register_write_address  (register_write_address),
    .register_write_data     (register_write_data),
    .bus_request             (bus_request),
    .bus_write               (bus_write),
    .bus_address             (bus_address),
    .bus_byte_select         (bus_byte_select),
    .bus_data_write          (bus_data_write),
    .bus_data_read           (bus_data_read),
    .bus_ack                 (bus_ack),
    .memory_error            (memory_error)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: access size in bytes from the operator (0 = not a memory op).
  function automatic int op_size(input logic [7:0] op);
    case (op)
      8'h20, 8'h24, 8'h28: return 1;
      8'h21, 8'h25, 8'h29: return 2;
      8'h23, 8'h2B:        return 4;
      default:             return 0;
    endcase
  endfunction

  function automatic bit op_is_store(input logic [7:0] op);
    return (op == 8'h28) || (op == 8'h29) || (op == 8'h2B);
  endfunction

  function automatic bit op_is_signed(input logic [7:0] op);
    return (op == 8'h20) || (op == 8'h21);
  endfunction

  function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
    int sz;
    longint unsigned v;
    sz = op_size(op);
    v  = (longint'(word) >> (8 * (addr % 4))) % (64'd1 << (8 * sz));
    if (op_is_signed(op) && v >= (64'd1 << (8 * sz - 1)))
      v = v + 64'h1_0000_0000 - (64'd1 << (8 * sz));
    return 32'(v);
  endfunction

  function automatic logic [31:0] model_store(input logic [7:0] op, input logic [31:0] sd);
    case (op_size(op))
      1:       return (sd % 256) * 32'h0101_0101;
      2:       return (sd % 65536) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  // Issues one instruction; expects to be entered just after a clock edge with
  // stall_request low. ack_lat = idle ACCESS cycles before the ack
  // (>= TIMEOUT means the bus never answers). Returns in the first cycle in
  // which the stage can accept the next instruction.
  task automatic do_op(input logic [7:0] op, input logic we, input logic [4:0] wa,
                       input logic [31:0] addr, input logic [31:0] sd,
                       input int ack_lat, input logic [31:0] rd);
    int  sz;
    bit  aligned;
    bit  aborted;
    logic [3:0] bsel;
    sz      = op_size(op);
    aligned = (sz == 0) || (addr % sz == 0);
    operator                = op;
    register_write_enable_  = we;
    register_write_address_ = wa;
    register_write_data_    = addr;
    store_data              = sd;
    bus_ack                 = 1'($urandom_range(0, 1));
    bus_data_read           = $urandom;
    @(posedge clock); #1;
    bus_ack = 1'b0;
    if (sz == 0) begin
      check("np_stall", stall_request, 0);
      check("np_busreq", bus_request, 0);
      check("np_err", memory_error, 0);
      check("np_we", register_write_enable, we);
      check("np_waddr", register_write_address, wa);
      check("np_data", register_write_data, addr);
    end else if (!aligned) begin
      check("mis_stall", stall_request, 0);
      check("mis_busreq", bus_request, 0);
      check("mis_err", memory_error, 1);
      check("mis_we", register_write_enable, 0);
    end else begin
      bsel    = 4'(((1 << sz) - 1) << (addr % 4));
      aborted = 1'b1;
      for (int c = 0; c < TIMEOUT; c++) begin
        check("acc_stall", stall_request, 1);
        check("acc_busreq", bus_request, 1);
        check("acc_write", bus_write, op_is_store(op));
        check("acc_addr", bus_address, addr - (addr % 4));
        check("acc_bsel", bus_byte_select, bsel);
        if (op_is_store(op)) check("acc_wdata", bus_data_write, model_store(op, sd));
        check("acc_we", register_write_enable, 0);
        check("acc_err", memory_error, 0);
        if (ack_lat == c) begin
          bus_ack       = 1'b1;
          bus_data_read = rd;
        end
        @(posedge clock); #1;
        bus_ack       = 1'b0;
        bus_data_read = $urandom;
        if (ack_lat == c) begin
          aborted = 1'b0;
          break;
        end
      end
      check("done_stall", stall_request, 0);
      check("done_busreq", bus_request, 0);
      check("done_err", memory_error, aborted);
      check("done_we", register_write_enable, we && !op_is_store(op) && !aborted);
      check("done_waddr", register_write_address, wa);
      if (!op_is_store(op) && !aborted)
        check("done_data", register_write_data, model_load(op, addr, rd));
    end
  endtask

  logic [7:0] mem_ops [8] = '{8'h20, 8'h21, 8'h23, 8'h24, 8'h25, 8'h28, 8'h29, 8'h2B};

  initial begin
    logic [7:0] op;
    reset                   = 1'b1;
    operator                = '0;
    register_write_enable_  = 1'b0;
    register_write_address_ = '0;
    register_write_data_    = '0;
    store_data              = '0;
    bus_data_read           = '0;
    bus_ack                 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_stall", stall_request, 0);
    check("rst_we", register_write_enable, 0);
    check("rst_data", register_write_data, 0);
    check("rst_busreq", bus_request, 0);
    check("rst_busaddr", bus_address, 0);
    check("rst_err", memory_error, 0);
    reset = 1'b0;

    // Directed cases.
    do_op(8'h01, 1'b1, 5'd3, 32'h0000_F0F0, 32'h0, 0, 32'h0);
    do_op(8'h23, 1'b1, 5'd4, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF);
    do_op(8'h20, 1'b1, 5'd5, 32'h0000_0103, 32'h0, 1, 32'h8012_3456);
    do_op(8'h24, 1'b1, 5'd6, 32'h0000_0103, 32'h0, 0, 32'h8012_3456);
    do_op(8'h29, 1'b1, 5'd7, 32'h0000_0102, 32'h0000_1234, 2, 32'h0);
    do_op(8'h23, 1'b1, 5'd8, 32'h0000_0101, 32'h0, 0, 32'h0);
    do_op(8'h23, 1'b1, 5'd9, 32'h0000_0200, 32'h0, TIMEOUT + 1, 32'h0);
    do_op(8'h25, 1'b1, 5'd3, 32'h0000_F0F0, 32'h0, 0, 32'h0000_9ABC);

    // Reset while an access is outstanding.
    operator             = 8'h23;
    register_write_data_ = 32'h0000_0300;
    register_write_enable_ = 1'b1;
    @(posedge clock); #1;
    check("rstacc_busreq_pre", bus_request, 1);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check("rstacc_busreq", bus_request, 0);
    check("rstacc_stall", stall_request, 0);
    check("rstacc_we", register_write_enable, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    check("rstacc_err", memory_error, 0);
    do_op(8'h07, 1'b1, 5'd11, 32'h1357_9BDF, 32'h0, 0, 32'h0);

    // Randomized mix of memory and non-memory operations.
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 3) == 0) begin
        op = 8'($urandom_range(0, 255));
      end else begin
        op = mem_ops[$urandom_range(0, 7)];
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_op(op, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), a, $urandom,
            int'($urandom_range(0, TIMEOUT + 1)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
